// File: rtl/arb_rsp_pkg.sv
// rtl/arb_rsp_pkg.sv - derived-width helpers shared by the response router and its ID queue
package arb_rsp_pkg;

  // Width of a master index; NumIn is at least 2 so $clog2 is never zero.
  function automatic int idx_w(input int num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

  // Width of an occupancy counter that must reach max_trans inclusive.
  function automatic int cnt_w(input int max_trans);
    return $clog2(max_trans + 1);
  endfunction

  // Width of a queue pointer; a single-entry queue still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/arb_idx_fifo.sv
// rtl/arb_idx_fifo.sv - in-order queue of source indices with combinational head
module arb_idx_fifo
  import arb_rsp_pkg::*;
#(
  parameter int Depth      = 4,
  parameter int Width      = 2,
  parameter int UsageWidth = cnt_w(Depth)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [Width-1:0]      data_i,
  input  logic                  pop_i,
  output logic [Width-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [UsageWidth-1:0] usage_o
);

  localparam int PtrWidth = ptr_w(Depth);
  localparam logic [PtrWidth-1:0]   LastPtr = PtrWidth'(Depth - 1);
  localparam logic [UsageWidth-1:0] FullCnt = UsageWidth'(Depth);

  logic [Width-1:0]      mem [Depth];
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [UsageWidth-1:0] count;

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [PtrWidth-1:0] adv(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= adv(wr_ptr);
      if (pop_i)  rd_ptr <= adv(rd_ptr);
      if (push_i && !pop_i)      count <= count + 1'b1;
      else if (!push_i && pop_i) count <= count - 1'b1;
    end
  end

  // Entry storage; stale contents after reset are never read because empty gates the head.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  assign data_o  = mem[rd_ptr];
  assign usage_o = count;
  assign full_o  = (count == FullCnt);
  assign empty_o = (count == '0);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/arb_rsp_router.sv
// rtl/arb_rsp_router.sv - forwards arbitrated requests to one slave and routes in-order responses back
module arb_rsp_router
  import arb_rsp_pkg::*;
#(
  parameter int NumIn    = 4,
  parameter int ReqWidth = 32,
  parameter int RspWidth = 32,
  parameter int MaxTrans = 4,
  parameter int IdxWidth = idx_w(NumIn),
  parameter int CntWidth = cnt_w(MaxTrans)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                arb_req_i,
  output logic                arb_gnt_o,
  input  logic [ReqWidth-1:0] arb_data_i,
  input  logic [IdxWidth-1:0] arb_idx_i,
  output logic                slv_req_o,
  input  logic                slv_gnt_i,
  output logic [ReqWidth-1:0] slv_data_o,
  input  logic                slv_rvalid_i,
  input  logic [RspWidth-1:0] slv_rdata_i,
  output logic                slv_rready_o,
  output logic [NumIn-1:0]    rsp_valid_o,
  output logic [RspWidth-1:0] rsp_data_o,
  input  logic [NumIn-1:0]    rsp_ready_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                unexp_rsp_o
);

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [IdxWidth-1:0] head;

  // Request gating: a full queue blocks the handshake even if a pop happens this cycle.
  always_comb begin
    slv_req_o  = arb_req_i & ~full;
    arb_gnt_o  = slv_gnt_i & ~full;
    slv_data_o = arb_data_i;
    push       = arb_req_i & slv_gnt_i & ~full;
  end

  // Response demux: only the master at the queue head sees valid and may accept.
  always_comb begin
    rsp_valid_o  = '0;
    slv_rready_o = 1'b0;
    if (!empty) begin
      rsp_valid_o[head] = slv_rvalid_i;
      slv_rready_o      = rsp_ready_i[head];
    end
  end

  assign rsp_data_o  = slv_rdata_i;
  assign pop         = slv_rvalid_i & slv_rready_o;
  assign unexp_rsp_o = slv_rvalid_i & empty;
  assign full_o      = full;
  assign empty_o     = empty;

  arb_idx_fifo #(
    .Depth      (MaxTrans),
    .Width      (IdxWidth),
    .UsageWidth (CntWidth)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (arb_idx_i),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (outstanding_o)
  );

  a_rsp_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid_o));
  a_idx_range:  assert property (@(posedge clk_i) disable iff (rst_i) push |-> (int'(arb_idx_i) < NumIn));

endmodule

// File: tb/tb_arb_rsp_router.sv
// tb/tb_arb_rsp_router.sv - scoreboard bench for arb_rsp_router at MaxTrans 4 and 3
module tb_arb_rsp_router;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_req;
  logic [31:0] arb_data;
  logic [1:0]  arb_idx;
  logic        slv_gnt;
  logic        slv_rvalid;
  logic [31:0] slv_rdata;
  logic [3:0]  rsp_ready;

  logic        arb_gnt_a, slv_req_a, slv_rready_a, full_a, empty_a, unexp_a;
  logic [31:0] slv_data_a, rsp_data_a;
  logic [3:0]  rsp_valid_a;
  logic [2:0]  outstanding_a;
  logic        arb_gnt_b, slv_req_b, slv_rready_b, full_b, empty_b, unexp_b;
  logic [31:0] slv_data_b, rsp_data_b;
  logic [3:0]  rsp_valid_b;
  logic [1:0]  outstanding_b;

  logic        sel_b = 1'b0;
  int          mmax  = 4;
  int          total = 0;
  int          bad   = 0;
  int          mq[$];
  logic [31:0] plan_q[$];
  exp_t        exp_q[$];

  wire         arb_gnt     = sel_b ? arb_gnt_b    : arb_gnt_a;
  wire         slv_req     = sel_b ? slv_req_b    : slv_req_a;
  wire         slv_rready  = sel_b ? slv_rready_b : slv_rready_a;
  wire         full        = sel_b ? full_b       : full_a;
  wire         empty       = sel_b ? empty_b      : empty_a;
  wire         unexp       = sel_b ? unexp_b      : unexp_a;
  wire  [31:0] slv_data    = sel_b ? slv_data_b   : slv_data_a;
  wire  [31:0] rsp_data    = sel_b ? rsp_data_b   : rsp_data_a;
  wire  [3:0]  rsp_valid   = sel_b ? rsp_valid_b  : rsp_valid_a;
  wire  [2:0]  outstanding = sel_b ? {1'b0, outstanding_b} : outstanding_a;

  always #5 clk = ~clk;

  arb_rsp_router #(.NumIn(4), .ReqWidth(32), .RspWidth(32), .MaxTrans(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .arb_req_i(arb_req), .arb_gnt_o(arb_gnt_a),
    .arb_data_i(arb_data), .arb_idx_i(arb_idx), .slv_req_o(slv_req_a),
    .slv_gnt_i(slv_gnt), .slv_data_o(slv_data_a), .slv_rvalid_i(slv_rvalid),
    .slv_rdata_i(slv_rdata), .slv_rready_o(slv_rready_a), .rsp_valid_o(rsp_valid_a),
    .rsp_data_o(rsp_data_a), .rsp_ready_i(rsp_ready), .outstanding_o(outstanding_a),
    .full_o(full_a), .empty_o(empty_a), .unexp_rsp_o(unexp_a)
  );

  arb_rsp_router #(.NumIn(4), .ReqWidth(32), .RspWidth(32), .MaxTrans(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .arb_req_i(arb_req), .arb_gnt_o(arb_gnt_b),
    .arb_data_i(arb_data), .arb_idx_i(arb_idx), .slv_req_o(slv_req_b),
    .slv_gnt_i(slv_gnt), .slv_data_o(slv_data_b), .slv_rvalid_i(slv_rvalid),
    .slv_rdata_i(slv_rdata), .slv_rready_o(slv_rready_b), .rsp_valid_o(rsp_valid_b),
    .rsp_data_o(rsp_data_b), .rsp_ready_i(rsp_ready), .outstanding_o(outstanding_b),
    .full_o(full_b), .empty_o(empty_b), .unexp_rsp_o(unexp_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any response presented to a master must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid != 4'b0000) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got rsp_valid %b with nothing queued", rsp_valid);
      end else begin
        chk("sb_valid", {28'b0, rsp_valid}, {28'b0, exp_q[0].vld});
        chk("sb_data", rsp_data, exp_q[0].data);
        if (slv_rvalid && slv_rready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; arb_req = 1'b0; arb_data = '0; arb_idx = '0; slv_gnt = 1'b0;
    slv_rvalid = 1'b0; slv_rdata = '0; rsp_ready = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    plan_q.delete();
    exp_q.delete();
  endtask

  // One clock: drive, check combinational outputs at negedge against the queue model, then advance it.
  task automatic cycle(input bit req, input int idx, input logic [31:0] rd,
                       input bit rv, input logic [3:0] rdy);
    int         occ;
    int         head;
    bit         mfull, mempty, mpush, mrready, mpop;
    logic [3:0] oh;
    exp_t       e;
    occ     = mq.size();
    mfull   = (occ == mmax);
    mempty  = (occ == 0);
    head    = mempty ? 0 : mq[0];
    oh      = 4'b0001 << head;
    mpush   = req && !mfull;
    mrready = !mempty && rdy[head];
    mpop    = rv && mrready;
    arb_req    = req;
    arb_idx    = idx[1:0];
    arb_data   = rd ^ 32'h5A5A_0000;
    slv_gnt    = req;
    slv_rvalid = rv;
    slv_rdata  = (plan_q.size() > 0) ? plan_q[0] : 32'hDEAD;
    rsp_ready  = rdy;
    @(negedge clk);
    chk("outstanding", {29'b0, outstanding}, occ);
    chk("full", {31'b0, full}, {31'b0, mfull});
    chk("empty", {31'b0, empty}, {31'b0, mempty});
    chk("slv_req", {31'b0, slv_req}, {31'b0, req && !mfull});
    chk("arb_gnt", {31'b0, arb_gnt}, {31'b0, req && !mfull});
    chk("slv_rready", {31'b0, slv_rready}, {31'b0, mrready});
    chk("unexp", {31'b0, unexp}, {31'b0, rv && mempty});
    chk("rsp_valid", {28'b0, rsp_valid}, (rv && !mempty) ? {28'b0, oh} : 32'b0);
    if (req) chk("slv_data", slv_data, rd ^ 32'h5A5A_0000);
    @(posedge clk);
    if (mpop) begin
      void'(mq.pop_front());
      void'(plan_q.pop_front());
    end
    if (mpush) begin
      mq.push_back(idx);
      plan_q.push_back(rd);
      e.vld  = 4'b0001 << idx;
      e.data = rd;
      exp_q.push_back(e);
    end
    #1;
  endtask

  initial begin
    // 1: reset state, then a single transaction from master 2
    do_reset();
    cycle(0, 0, 0, 0, 4'b0000);
    cycle(1, 2, 32'hCAFE, 0, 4'b0000);
    cycle(0, 0, 0, 1, 4'b0100);
    cycle(0, 0, 0, 0, 4'b0000);
    chk("t1_drained", exp_q.size(), 0);

    // 2: fill to full, blocked fifth request, then drain in order
    for (int i = 0; i < 4; i++) cycle(1, i, 32'h100 + i, 0, 4'b0000);
    cycle(1, 1, 32'h1FF, 0, 4'b0000);
    chk("t2_full", {31'b0, full}, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 4'b0001 << i);
    chk("t2_drained", exp_q.size(), 0);

    // 3: head backpressure stalls a later master that is ready
    cycle(1, 1, 32'hB1, 0, 4'b0000);
    cycle(1, 3, 32'hB3, 0, 4'b0000);
    cycle(0, 0, 0, 1, 4'b1000);
    cycle(0, 0, 0, 1, 4'b1000);
    cycle(0, 0, 0, 1, 4'b0010);
    cycle(0, 0, 0, 1, 4'b1000);
    chk("t3_drained", exp_q.size(), 0);

    // 5: response while empty
    cycle(0, 0, 0, 1, 4'b1111);
    cycle(0, 0, 0, 0, 4'b0000);

    // 4: simultaneous push/pop at occupancy 2 on the depth-3 instance
    sel_b = 1'b1;
    mmax  = 3;
    do_reset();
    cycle(1, 0, 32'h40, 0, 4'b0000);
    cycle(1, 1, 32'h41, 0, 4'b0000);
    for (int i = 2; i < 12; i++) cycle(1, i % 4, 32'h40 + i, 1, 4'b1111);
    chk("t4_occ", {29'b0, outstanding}, 2);
    cycle(0, 0, 0, 1, 4'b1111);
    cycle(0, 0, 0, 1, 4'b1111);
    cycle(0, 0, 0, 0, 4'b0000);
    chk("t4_drained", exp_q.size(), 0);

    // 6: reset with three entries queued discards them
    sel_b = 1'b0;
    mmax  = 4;
    for (int i = 0; i < 3; i++) cycle(1, 3 - i, 32'h60 + i, 0, 4'b0000);
    chk("t6_occ", {29'b0, outstanding}, 3);
    do_reset();
    cycle(0, 0, 0, 1, 4'b1111);
    cycle(0, 0, 0, 0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_rsp_router.md
Name: arb_rsp_router

Overview:
- Sits directly downstream of the round-robin arbitration tree.
- Accepts the arbitrated request (req/gnt, data, source index) and forwards it to a single shared slave port.
- Records each accepted source index in an in-order ID queue.
- When slave responses return in order, routes each one back to the originating input.
- Closes the request/response loop for multi-master sharing of one in-order unit.

Parameters:
- NumIn, 4, number of arbitrated masters; must be ≥2.
- ReqWidth, 32, request payload width in bits.
- RspWidth, 32, response payload width in bits.
- MaxTrans, 4, maximum outstanding transactions (ID queue depth); ≥1; non-power-of-two allowed.
- IdxWidth, $clog2(NumIn), derived; do not override.
- CntWidth, $clog2(MaxTrans+1), derived; do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- arb_req_i  in  1  arbitrated request valid.
- arb_gnt_o  out  1  arbitrated request accepted.
- arb_data_i  in  ReqWidth  arbitrated request payload.
- arb_idx_i  in  IdxWidth  source index of arbitrated request.
- slv_req_o  out  1  request to slave.
- slv_gnt_i  in  1  slave accepts request.
- slv_data_o  out  ReqWidth  request payload to slave.
- slv_rvalid_i  in  1  slave response valid.
- slv_rdata_i  in  RspWidth  slave response payload.
- slv_rready_o  out  1  response accepted.
- rsp_valid_o  out  NumIn  per-master response valid (one-hot or zero).
- rsp_data_o  out  RspWidth  response payload, broadcast to all masters.
- rsp_ready_i  in  NumIn  per-master response ready.
- outstanding_o  out  CntWidth  current queue occupancy.
- full_o  out  1  occupancy == MaxTrans.
- empty_o  out  1  occupancy == 0.
- unexp_rsp_o  out  1  slv_rvalid_i seen while empty.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset state: read pointer, write pointer and count = 0.
  - Hence outstanding_o=0, empty_o=1, full_o=0, rsp_valid_o=0, slv_rready_o=0, unexp_rsp_o=0.
- Request path (combinational, zero latency):
  - slv_req_o = arb_req_i & ~full_o.
  - slv_data_o = arb_data_i.
  - arb_gnt_o = slv_gnt_i & ~full_o.
  - Push = arb_req_i & slv_gnt_i & ~full_o; it writes arb_idx_i at the write pointer.
- Full: requests are blocked even if a pop occurs in the same cycle (no full-bypass). The arbiter sees gnt=0 and holds its decision.
- Response path (combinational from queue head H):
  - rsp_valid_o[H] = slv_rvalid_i & ~empty_o; all other bits 0.
  - rsp_data_o = slv_rdata_i.
  - slv_rready_o = rsp_ready_i[H] & ~empty_o.
  - Pop = slv_rvalid_i & slv_rready_o.
- Backpressure: a master not ready stalls all later responses (in-order). rsp_ready_i of non-head masters is ignored.
- Empty queue:
  - slv_rvalid_i=1 → unexp_rsp_o=1 that cycle.
  - slv_rready_o=0; response is not consumed; state unchanged.
  - No same-cycle push→pop bypass: slave response latency is ≥1 cycle after the request handshake.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointer wrap: a pointer at MaxTrans-1 advances to 0 (explicit compare, not power-of-two overflow).
- Count update: count_next = count + push − pop, within 0..MaxTrans. Overflow and underflow are impossible by construction.
- Reset mid-operation: all queued indices are discarded. The slave must be reset together with this block; any late response is flagged by unexp_rsp_o.
- Handshake stability: arb_idx_i and arb_data_i are only sampled in the push cycle. No requirement on stability while blocked, beyond the arbiter's own LockIn.
- Assertions (sim only):
  - $onehot0(rsp_valid_o).
  - No push when full.
  - No pop when empty.
  - arb_idx_i < NumIn on push.

Decomposition:
- Shared package arb_rsp_pkg: derived-width helper functions. No typedefs are needed beyond idx/cnt widths, which are derived in the module.
- Sub-module arb_idx_fifo:
  - Parameterised Depth and Width.
  - Synchronous active-high reset.
  - push/pop/full/empty/usage; head data visible combinationally.
  - Holds the pointer and count logic.
- The top level contains only request gating, head decode, and the response mux/demux.

Test Plan:
1. Reset then single transaction: NumIn=4, MaxTrans=4, arb_req_i=1, idx=2, slv_gnt_i=1 → push, outstanding_o=1; next cycle slv_rvalid_i=1, rdata=0xCAFE, rsp_ready_i=4'b0100 → rsp_valid_o=4'b0100, rsp_data_o=0xCAFE, pop, empty_o=1.
2. Fill to full: 4 pushes with idx 0,1,2,3 and no responses → full_o=1, 5th request sees slv_req_o=0, arb_gnt_o=0. Then 4 responses → rsp_valid_o=0001,0010,0100,1000 in order.
3. Head backpressure: queue idx 1,3; rsp_ready_i=4'b1000 while slv_rvalid_i=1 → slv_rready_o=0 and no pop; raise bit1 → pop of idx 1, then idx 3 is served.
4. Simultaneous push/pop at occupancy 2 with MaxTrans=3 over 10 cycles → outstanding_o stays 2, pointers wrap 2→0 correctly, order preserved.
5. Unexpected response: empty, slv_rvalid_i=1 → unexp_rsp_o=1, slv_rready_o=0, rsp_valid_o=0, outstanding_o stays 0.
6. Reset mid-operation: occupancy 3, assert rst_i for one cycle → outstanding_o=0, empty_o=1, rsp_valid_o=0 on the cycle after reset.
